// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared encodings for the load/store unit: access-kind codes, FSM state
// type, and helpers that classify a request before it is issued.
//   is_load        : load code names a real load
//   is_mem_access  : request needs a memory transaction or a misalign report
//   is_misaligned  : request cannot be issued as a single aligned access
package ysyx_22041211_lsu_pkg;

  localparam logic [1:0] StoreInvalid = 2'b00;
  localparam logic [1:0] StoreSb      = 2'b01;
  localparam logic [1:0] StoreSh      = 2'b10;
  localparam logic [1:0] StoreSw      = 2'b11;

  localparam logic [2:0] LoadInvalid  = 3'b000;
  localparam logic [2:0] LoadLb       = 3'b001;
  localparam logic [2:0] LoadLh       = 3'b010;
  localparam logic [2:0] LoadLw       = 3'b011;
  localparam logic [2:0] LoadLbu      = 3'b100;
  localparam logic [2:0] LoadLhu      = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10,
    StDone = 2'b11
  } lsu_state_e;

  function automatic logic is_load(input logic [2:0] load_type);
    return (load_type == LoadLb) || (load_type == LoadLh) || (load_type == LoadLw) ||
           (load_type == LoadLbu) || (load_type == LoadLhu);
  endfunction

  function automatic logic is_mem_access(input logic [2:0] load_type,
                                         input logic [1:0] store_type);
    return is_load(load_type) || (store_type != StoreInvalid);
  endfunction

  // A request carrying both a load and a store kind is malformed; it is
  // reported through the misalign path so it never reaches memory.
  function automatic logic is_misaligned(input logic [2:0] load_type,
                                         input logic [1:0] store_type,
                                         input logic [1:0] addr_lo);
    logic half;
    logic word;
    half = (store_type == StoreSh) || (load_type == LoadLh) || (load_type == LoadLhu);
    word = (store_type == StoreSw) || (load_type == LoadLw);
    return (is_load(load_type) && (store_type != StoreInvalid)) ||
           (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Combinational lane steering for the LSU.
//   addr_lo    : low two address bits selecting the byte lane
//   load_type  : load kind; selects extract width and sign/zero extension
//   store_type : store kind; selects write mask and data lane
//   wdata      : store data as read from rs2
//   rdata      : raw 32-bit word returned by memory
//   wmask      : byte write enables (zero for loads)
//   wdata_lane : store data shifted into its byte lanes
//   load_data  : extracted and extended load result (zero for non-loads)
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [31:0] rshift;

  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = 32'd0;
    load_data  = 32'd0;
    // Bring the addressed byte/half down to bit 0 before extraction.
    rshift     = rdata >> {addr_lo, 3'b000};

    unique case (store_type)
      StoreSb: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {24'd0, wdata[7:0]} << {addr_lo, 3'b000};
      end
      StoreSh: begin
        wmask      = 4'b0011 << addr_lo;
        wdata_lane = {16'd0, wdata[15:0]} << {addr_lo[1], 4'b0000};
      end
      StoreSw: begin
        wmask      = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase

    unique case (load_type)
      LoadLb:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      LoadLbu: load_data = {24'd0, rshift[7:0]};
      LoadLh:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      LoadLhu: load_data = {16'd0, rshift[15:0]};
      LoadLw:  load_data = rshift;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: accepts one access from execute, issues at most one
// aligned memory transaction, and reports completion with a one-cycle pulse.
//   req_valid_i/req_ready_o        : execute handshake (ready only when idle)
//   load_type_i/store_type_i       : decoded access kind
//   addr_i/wdata_i/rd_i/wd_i       : address, store data, writeback target
//   mem_req_valid_o/mem_req_ready_i: memory request handshake
//   mem_addr_o/mem_wen_o/mem_wdata_o/mem_wmask_o : memory request payload
//   mem_rsp_valid_i/mem_rdata_i    : memory response / write ack
//   done_valid_o/load_data_o/rd_o/wd_o/misalign_o: completion report
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  store_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  input  logic        wd_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        done_valid_o,
  output logic [31:0] load_data_o,
  output logic [4:0]  rd_o,
  output logic        wd_o,
  output logic        misalign_o
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  load_type_q;
  logic [1:0]  store_type_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        wd_q;
  logic        misalign_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        capture;
  logic        req_misalign;
  logic [3:0]  lane_wmask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign accept       = (state_q == StIdle) && req_valid_i;
  assign capture      = (state_q == StWait) && mem_rsp_valid_i;
  assign req_misalign = is_misaligned(load_type_i, store_type_i, addr_i[1:0]);

  // Steering works only from latched request state, so nothing on the
  // request side can reach the memory outputs combinationally.
  ysyx_22041211_lsu_align u_align (
    .addr_lo    (addr_q[1:0]),
    .load_type  (load_type_q),
    .store_type (store_type_q),
    .wdata      (wdata_q),
    .rdata      (rdata_q),
    .wmask      (lane_wmask),
    .wdata_lane (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= 32'd0;
      load_type_q  <= LoadInvalid;
      store_type_q <= StoreInvalid;
      wdata_q      <= 32'd0;
      rd_q         <= 5'd0;
      wd_q         <= 1'b0;
      misalign_q   <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q       <= addr_i;
        load_type_q  <= load_type_i;
        store_type_q <= store_type_i;
        wdata_q      <= wdata_i;
        rd_q         <= rd_i;
        wd_q         <= wd_i;
        misalign_q   <= req_misalign;
      end
      if (capture) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = (is_mem_access(load_type_i, store_type_i) && !req_misalign) ? StReq
                                                                                  : StDone;
        end
      end
      StReq:   if (mem_req_ready_i) state_d = StWait;
      StWait:  if (mem_rsp_valid_i) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced to zero outside the state in which they are meaningful.
  always_comb begin
    req_ready_o     = (state_q == StIdle);
    mem_req_valid_o = 1'b0;
    mem_addr_o      = 32'd0;
    mem_wen_o       = 1'b0;
    mem_wdata_o     = 32'd0;
    mem_wmask_o     = 4'b0000;
    done_valid_o    = 1'b0;
    load_data_o     = 32'd0;
    rd_o            = 5'd0;
    wd_o            = 1'b0;
    misalign_o      = 1'b0;

    if (state_q == StReq) begin
      mem_req_valid_o = 1'b1;
      mem_addr_o      = {addr_q[31:2], 2'b00};
      mem_wen_o       = (store_type_q != StoreInvalid);
      mem_wdata_o     = lane_wdata;
      mem_wmask_o     = lane_wmask;
    end

    if (state_q == StDone) begin
      done_valid_o = 1'b1;
      rd_o         = rd_q;
      misalign_o   = misalign_q;
      wd_o         = wd_q && !misalign_q;
      load_data_o  = misalign_q ? 32'd0 : lane_load;
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
module tb_ysyx_22041211_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        wd_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_wen_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;
  logic        done_valid_o;
  logic [31:0] load_data_o;
  logic [4:0]  rd_o;
  logic        wd_o;
  logic        misalign_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_22041211_lsu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .load_type_i     (load_type_i),
    .store_type_i    (store_type_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .rd_i            (rd_i),
    .wd_i            (wd_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_wen_o       (mem_wen_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wmask_o     (mem_wmask_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rdata_i     (mem_rdata_i),
    .done_valid_o    (done_valid_o),
    .load_data_o     (load_data_o),
    .rd_o            (rd_o),
    .wd_o            (wd_o),
    .misalign_o      (misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, lane offset, and the resulting memory
  // image / load value computed with plain integer arithmetic.
  task automatic model(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] wv, input logic [31:0] rv,
                       output bit mem, output bit mis, output logic [3:0] mask,
                       output logic [31:0] wword, output logic [31:0] ld);
    int unsigned off, size, m;
    bit ld_ok, st_ok;
    longint unsigned v, lim, w64, r64;
    off   = a % 4;
    ld_ok = (lt >= 1) && (lt <= 5);
    st_ok = (st != 0);
    if (st_ok) size = (st == 1) ? 1 : (st == 2) ? 2 : 4;
    else       size = (lt == 1 || lt == 4) ? 1 : (lt == 2 || lt == 5) ? 2 : 4;
    mis   = (ld_ok && st_ok) || ((ld_ok || st_ok) && (off % size != 0));
    mem   = (ld_ok || st_ok) && !mis;
    lim   = 64'd1 << (8 * size);
    w64   = {32'd0, wv};
    r64   = {32'd0, rv};
    mask  = 4'd0;
    wword = 32'd0;
    ld    = 32'd0;
    if (mem && st_ok) begin
      m     = ((32'd1 << size) - 1) << off;
      mask  = m[3:0];
      v     = (w64 % lim) << (8 * off);
      wword = v[31:0];
    end
    if (mem && ld_ok) begin
      v = (r64 >> (8 * off)) % lim;
      if ((lt == 1 || lt == 2) && v >= lim / 2) v = v - lim;
      ld = v[31:0];
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, req_ready_o, 1'b1);
    chk({tag, "_mreqv"}, mem_req_valid_o, 1'b0);
    chk({tag, "_maddr"}, mem_addr_o, 32'd0);
    chk({tag, "_mwen"}, mem_wen_o, 1'b0);
    chk({tag, "_mwdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_mwmask"}, mem_wmask_o, 4'd0);
    chk({tag, "_done"}, done_valid_o, 1'b0);
    chk({tag, "_ldata"}, load_data_o, 32'd0);
    chk({tag, "_rd"}, rd_o, 5'd0);
    chk({tag, "_wd"}, wd_o, 1'b0);
    chk({tag, "_mis"}, misalign_o, 1'b0);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_txn(input string tag, input logic [2:0] lt, input logic [1:0] st,
                        input logic [31:0] a, input logic [31:0] wv, input logic [4:0] rd,
                        input logic wdv, input logic [31:0] rv, input int rdy_dly,
                        input int rsp_dly);
    bit mem, mis;
    logic [3:0] mask;
    logic [31:0] wword, ld;
    model(lt, st, a, wv, rv, mem, mis, mask, wword, ld);
    req_valid_i = 1'b1; load_type_i = lt; store_type_i = st;
    addr_i = a; wdata_i = wv; rd_i = rd; wd_i = wdv;
    @(negedge clk);
    chk({tag, "_accept_ready"}, req_ready_o, 1'b1);
    chk({tag, "_accept_done"}, done_valid_o, 1'b0);
    @(posedge clk); #1;
    // Scramble request inputs: the DUT must work from latched copies.
    req_valid_i = 1'b0; load_type_i = 3'($urandom); store_type_i = 2'($urandom);
    addr_i = $urandom; wdata_i = $urandom; rd_i = 5'($urandom); wd_i = 1'($urandom);
    if (mem) begin
      for (int k = 0; k <= rdy_dly; k++) begin
        mem_req_ready_i = (k == rdy_dly);
        mem_rsp_valid_i = 1'($urandom);
        mem_rdata_i     = $urandom;
        @(negedge clk);
        chk({tag, "_req_valid"}, mem_req_valid_o, 1'b1);
        chk({tag, "_req_addr"}, mem_addr_o, {a[31:2], 2'b00});
        chk({tag, "_req_wen"}, mem_wen_o, (st != 0));
        chk({tag, "_req_wdata"}, mem_wdata_o, wword);
        chk({tag, "_req_wmask"}, mem_wmask_o, mask);
        chk({tag, "_req_ready"}, req_ready_o, 1'b0);
        chk({tag, "_req_done"}, done_valid_o, 1'b0);
        @(posedge clk); #1;
      end
      mem_req_ready_i = 1'b0;
      for (int k = 0; k <= rsp_dly; k++) begin
        mem_rsp_valid_i = (k == rsp_dly);
        mem_rdata_i     = (k == rsp_dly) ? rv : $urandom;
        @(negedge clk);
        chk({tag, "_wait_valid"}, mem_req_valid_o, 1'b0);
        chk({tag, "_wait_done"}, done_valid_o, 1'b0);
        @(posedge clk); #1;
      end
      mem_rsp_valid_i = 1'b0;
      mem_rdata_i     = $urandom;
    end
    @(negedge clk);
    chk({tag, "_done_valid"}, done_valid_o, 1'b1);
    chk({tag, "_done_mreqv"}, mem_req_valid_o, 1'b0);
    chk({tag, "_done_mis"}, misalign_o, mis);
    chk({tag, "_done_wd"}, wd_o, mis ? 1'b0 : wdv);
    chk({tag, "_done_ldata"}, load_data_o, ld);
    if (!mis) chk({tag, "_done_rd"}, rd_o, rd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; load_type_i = 3'd0; store_type_i = 2'd0;
    addr_i = 32'd0; wdata_i = 32'd0; rd_i = 5'd0; wd_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;

    // Directed cases.
    do_txn("sb_lane3", 3'd0, 2'd1, 32'h8000_0003, 32'h1234_56AB, 5'd0, 1'b0, 32'd0, 0, 0);
    do_txn("lb_sext", 3'd1, 2'd0, 32'h8000_0001, 32'd0, 5'd7, 1'b1, 32'h0000_F000, 0, 0);
    do_txn("lbu_zext", 3'd4, 2'd0, 32'h8000_0001, 32'd0, 5'd8, 1'b1, 32'h0000_F000, 0, 1);
    do_txn("lh_sext", 3'd2, 2'd0, 32'h8000_0002, 32'd0, 5'd9, 1'b1, 32'h8001_1234, 1, 0);
    do_txn("lhu_zext", 3'd5, 2'd0, 32'h8000_0002, 32'd0, 5'd10, 1'b1, 32'h8001_1234, 0, 0);
    do_txn("sw_mis", 3'd0, 2'd3, 32'h8000_0002, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'd0, 0, 0);
    do_txn("stall5", 3'd3, 2'd0, 32'h8000_0104, 32'd0, 5'd11, 1'b1, 32'hCAFE_F00D, 5, 2);
    do_txn("nonmem", 3'd0, 2'd0, 32'h8000_0000, 32'd0, 5'd5, 1'b1, 32'd0, 0, 0);
    do_txn("both_types", 3'd3, 2'd3, 32'h8000_0000, 32'h1, 5'd6, 1'b1, 32'd0, 0, 0);
    do_txn("sh_hi", 3'd0, 2'd2, 32'h8000_0012, 32'hAAAA_5A5A, 5'd0, 1'b0, 32'd0, 0, 0);

    // Reset while waiting for a response abandons the access.
    req_valid_i = 1'b1; load_type_i = 3'd3; store_type_i = 2'd0; addr_i = 32'h8000_0010;
    rd_i = 5'd12; wd_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_wait_pre_mreqv", mem_req_valid_o, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst_wait_post");
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_late_rsp_done", done_valid_o, 1'b0);
      chk("rst_late_rsp_mreqv", mem_req_valid_o, 1'b0);
    end
    @(posedge clk); #1;
    mem_rsp_valid_i = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [2:0] lt;
      logic [1:0] st;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      lt = 3'd0;
      st = 2'd0;
      if (kind == 0 || kind == 3) lt = 3'($urandom_range(1, 5));
      if (kind == 1 || kind == 3) st = 2'($urandom_range(1, 3));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      do_txn("rand", lt, st, a, $urandom, 5'($urandom), 1'($urandom), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk_idle("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
